// File: rtl/wb_stage_buf.sv
// Two-entry write-back skid buffer (MAIN head + SKID): 1-cycle accept-to-wb latency, 1 entry/cycle.
// in_ready = !SKID.valid, registered only; rdy low freezes all state. Optional retire_cnt behind WB_PERF_CNT_EN.
module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e state_q, state_d;
  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t cap_ent;
  logic accept;
  logic pop;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & rdy & ~flush;
  assign pop       = out_valid & out_ready & rdy;

  // Writes to x0 are dropped at capture so the register file never sees them.
  always_comb begin
    cap_ent.we    = in_we & (in_waddr != '0);
    cap_ent.waddr = in_waddr;
    cap_ent.wdata = in_wdata;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (rdy) begin
      if (flush) begin
        state_d = EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              main_d  = cap_ent;
              state_d = ONE;
            end
          end
          ONE: begin
            if (pop && accept) begin
              main_d = cap_ent;
            end else if (pop) begin
              main_d  = '0;
              state_d = EMPTY;
            end else if (accept) begin
              skid_d  = cap_ent;
              state_d = FULL;
            end
          end
          FULL: begin
            // in_ready is low here, so only a pop can move state.
            if (pop) begin
              main_d  = skid_q;
              skid_d  = '0;
              state_d = ONE;
            end
          end
          default: begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign wb_we    = out_valid & main_q.we;
  assign wb_waddr = out_valid ? main_q.waddr : '0;
  assign wb_wdata = out_valid ? main_q.wdata : '0;

`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (pop && wb_we) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  // No retirement counter in this build.
`endif

endmodule
